// File: rtl/ysyx_23060062_mem_arbiter.sv
// Shares the core's single memory port between IFU fetches and LSU loads/stores, one transaction at a time.
// Define YSYX_23060062_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ysyx_23060062_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_lsu;
    logic [TMR_W-1:0]  timer;
    logic              accept;
    logic              grant_lsu;
    logic              mem_hs;
    logic              resp_hit;
    logic              tmo_hit;
    logic              finish;
`ifdef YSYX_23060062_ARB_RR_EN
    logic              last_lsu;
`endif

    // Writes and timeouts return zero data; only a real read response carries mem_rdata.
    function automatic logic [DATA_W-1:0] resp_data(input logic                hit,
                                                     input logic                is_write,
                                                     input logic [DATA_W-1:0]   rdata);
        return (hit && !is_write) ? rdata : '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        accept        = 1'b0;
        grant_lsu     = 1'b0;
        mem_hs        = 1'b0;
        resp_hit      = 1'b0;
        tmo_hit       = 1'b0;
        finish        = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
`ifdef YSYX_23060062_ARB_RR_EN
                if (lsu_req_valid && ifu_req_valid) begin
                    grant_lsu = !last_lsu;
                end else begin
                    grant_lsu = lsu_req_valid;
                end
`else
                grant_lsu = lsu_req_valid;
`endif
                lsu_req_ready = grant_lsu;
                ifu_req_ready = ifu_req_valid && !grant_lsu;
                accept        = lsu_req_ready || ifu_req_ready;
                if (accept) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_hs        = mem_req_ready;
                if (mem_hs) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_hit = mem_resp_valid;
                // A response arriving on the last watchdog cycle still wins over the timeout.
                tmo_hit  = (TIMEOUT != 0) && (timer == TMR_LAST) && !mem_resp_valid;
                finish   = resp_hit || tmo_hit;
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_lsu      <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            timer          <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_resp_err   <= 1'b0;
`ifdef YSYX_23060062_ARB_RR_EN
            last_lsu       <= 1'b0;
`endif
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;

            if (accept) begin
                owner_lsu <= grant_lsu;
                if (grant_lsu) begin
                    mem_addr  <= lsu_addr;
                    mem_wen   <= lsu_wen;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wmask;
                end else begin
                    mem_addr  <= ifu_addr;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    mem_wmask <= '0;
                end
`ifdef YSYX_23060062_ARB_RR_EN
                last_lsu <= grant_lsu;
`endif
            end

            if (mem_hs) begin
                timer <= '0;
            end else if (state == RESP) begin
                timer <= timer + 1'b1;
            end

            if (finish) begin
                if (owner_lsu) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_rdata      <= resp_data(resp_hit, mem_wen, mem_rdata);
                    lsu_resp_err   <= tmo_hit;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_rdata      <= resp_data(resp_hit, 1'b0, mem_rdata);
                    ifu_resp_err   <= tmo_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060062_mem_arbiter.sv
// Directed bench for ysyx_23060062_mem_arbiter: behavioural memory, response scoreboard, latency checks.
module tb_ysyx_23060062_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_resp_err;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [DW/8-1:0] lsu_wmask = '0;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          lsu_resp_err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    ysyx_23060062_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        bit          err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Behavioural memory: programmable request-ready delay and response delay.
    int          ready_delay = 0;
    int          resp_delay = 0;
    bit          resp_en = 1'b1;
    bit          force_resp = 1'b0;
    int          req_wait = 0;
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [31:0] rd = '0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ 32'hA5A5_0F0F;
    endfunction

    assign mem_req_ready  = mem_req_valid && (req_wait >= ready_delay);
    assign mem_resp_valid = (pending && cnt == 0 && resp_en) || force_resp;
    assign mem_rdata      = rd;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req_valid && !mem_req_ready) req_wait <= req_wait + 1;
        else req_wait <= 0;
        if (mem_req_valid && mem_req_ready) begin
            pending <= 1'b1;
            cnt     <= resp_delay;
            rd      <= mem_fn(mem_addr);
        end else if (pending) begin
            if (cnt == 0) pending <= 1'b0;
            else cnt <= cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (ifu_resp_valid || lsu_resp_valid) begin
            chk("resp_exclusive", {31'b0, ifu_resp_valid & lsu_resp_valid}, 32'h0);
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_owner_lsu", {31'b0, lsu_resp_valid}, {31'b0, mon_e.lsu});
                chk("resp_data", mon_e.lsu ? lsu_rdata : ifu_rdata, mon_e.data);
                chk("resp_err", {31'b0, mon_e.lsu ? lsu_resp_err : ifu_resp_err}, {31'b0, mon_e.err});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input bit lsu, input logic [31:0] data, input bit err);
        exp_t e;
        e.lsu = lsu;
        e.data = data;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input bit lsu, input string tag);
        int n = 0;
        #1;
        while (!(lsu ? lsu_req_ready : ifu_req_ready) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk(tag, {31'b0, lsu ? lsu_req_ready : ifu_req_ready}, 32'h1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk(tag, exp_q.size(), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit exp_lsu [4];
        int acc [3];
        int n;

        // Power-on reset
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wen", {31'b0, mem_wen}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'h0);
        chk("rst_ifu_resp_valid", {31'b0, ifu_resp_valid}, 32'h0);
        chk("rst_lsu_resp_valid", {31'b0, lsu_resp_valid}, 32'h0);
        chk("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk("rst_lsu_rdata", lsu_rdata, 32'h0);

        // IFU fetch at minimum latency
        ifu_addr = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        wait_ready(1'b0, "ifu_grant_wait");
        push(1'b0, 32'h0000_0413, 1'b0);
        tick();
        ifu_req_valid = 1'b0;
        chk("ifu_mem_req_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("ifu_mem_addr", mem_addr, 32'h8000_0000);
        chk("ifu_mem_wen", {31'b0, mem_wen}, 32'h0);
        chk("ifu_mem_wmask", {28'b0, mem_wmask}, 32'h0);
        chk("ifu_busy", {31'b0, busy}, 32'h1);
        tick();
        chk("ifu_req_dropped", {31'b0, mem_req_valid}, 32'h0);
        chk("ifu_no_early_resp", {31'b0, ifu_resp_valid}, 32'h0);
        tick();
        chk("ifu_resp_n3", {31'b0, ifu_resp_valid}, 32'h1);
        chk("ifu_rdata_n3", ifu_rdata, 32'h0000_0413);
        chk("ifu_idle_n3", {31'b0, busy}, 32'h0);
        tick();
        chk("ifu_pulse_one_cycle", {31'b0, ifu_resp_valid}, 32'h0);

        // LSU write with memory ready delayed 3 cycles
        ready_delay = 3;
        lsu_addr = 32'h8000_1000;
        lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'h3;
        lsu_req_valid = 1'b1;
        wait_ready(1'b1, "lsu_w_grant_wait");
        push(1'b1, 32'h0, 1'b0);
        tick();
        lsu_req_valid = 1'b0;
        lsu_wen = 1'b0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lsu_w_hold_valid_%0d", i), {31'b0, mem_req_valid}, 32'h1);
            chk($sformatf("lsu_w_hold_addr_%0d", i), mem_addr, 32'h8000_1000);
            chk($sformatf("lsu_w_hold_wdata_%0d", i), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("lsu_w_hold_wmask_%0d", i), {28'b0, mem_wmask}, 32'h3);
            chk($sformatf("lsu_w_hold_wen_%0d", i), {31'b0, mem_wen}, 32'h1);
            tick();
        end
        chk("lsu_w_req_at_hs", {31'b0, mem_req_valid}, 32'h1);
        tick();
        tick();
        chk("lsu_w_resp", {31'b0, lsu_resp_valid}, 32'h1);
        chk("lsu_w_rdata_zero", lsu_rdata, 32'h0);
        ready_delay = 0;
        tick();

        // Watchdog: memory never answers
        resp_en = 1'b0;
        lsu_addr = 32'h0000_0300;
        lsu_req_valid = 1'b1;
        wait_ready(1'b1, "tmo_grant_wait");
        push(1'b1, 32'h0, 1'b1);
        tick();
        lsu_req_valid = 1'b0;
        repeat (8) tick();
        chk("tmo_not_yet", {31'b0, lsu_resp_valid}, 32'h0);
        chk("tmo_still_busy", {31'b0, busy}, 32'h1);
        tick();
        chk("tmo_resp", {31'b0, lsu_resp_valid}, 32'h1);
        chk("tmo_err", {31'b0, lsu_resp_err}, 32'h1);
        chk("tmo_rdata", lsu_rdata, 32'h0);
        chk("tmo_idle", {31'b0, busy}, 32'h0);
        force_resp = 1'b1;
        tick();
        force_resp = 1'b0;
        chk("late_resp_lsu", {31'b0, lsu_resp_valid}, 32'h0);
        chk("late_resp_ifu", {31'b0, ifu_resp_valid}, 32'h0);
        tick();
        chk("late_resp_lsu_2", {31'b0, lsu_resp_valid}, 32'h0);

        // Reset asserted while waiting in RESP
        ifu_addr = 32'h0000_0040;
        ifu_req_valid = 1'b1;
        wait_ready(1'b0, "rstmid_grant_wait");
        tick();
        ifu_req_valid = 1'b0;
        tick();
        tick();
        chk("rstmid_busy_before", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_async_busy", {31'b0, busy}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        resp_en = 1'b1;
        tick();
        chk("rstmid_busy", {31'b0, busy}, 32'h0);
        chk("rstmid_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rstmid_ifu_resp", {31'b0, ifu_resp_valid}, 32'h0);
        chk("rstmid_lsu_resp", {31'b0, lsu_resp_valid}, 32'h0);
        repeat (10) tick();
        ifu_addr = 32'h8000_0000;
        ifu_req_valid = 1'b1;
        wait_ready(1'b0, "rstmid_refetch_wait");
        push(1'b0, 32'h0000_0413, 1'b0);
        tick();
        ifu_req_valid = 1'b0;
        chk("rstmid_refetch_addr", mem_addr, 32'h8000_0000);
        drain("rstmid_refetch_drain");

        // Contention: both requesters valid for 4 transactions
`ifdef YSYX_23060062_ARB_RR_EN
        exp_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        ifu_addr = 32'h0000_0100;
        lsu_addr = 32'h0000_0200;
        lsu_wen = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(ifu_req_ready || lsu_req_ready) && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("cont_lsu_ready_%0d", k), {31'b0, lsu_req_ready}, {31'b0, exp_lsu[k]});
            chk($sformatf("cont_ifu_ready_%0d", k), {31'b0, ifu_req_ready}, {31'b0, !exp_lsu[k]});
            push(exp_lsu[k], mem_fn(exp_lsu[k] ? 32'h0000_0200 : 32'h0000_0100), 1'b0);
            tick();
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        drain("cont_drain");

        // Back-to-back IFU fetches with zero-wait memory
        ifu_addr = 32'h0;
        ifu_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready(1'b0, $sformatf("b2b_grant_wait_%0d", k));
            acc[k] = cyc;
            push(1'b0, mem_fn(32'(k * 4)), 1'b0);
            tick();
            ifu_addr = 32'((k + 1) * 4);
        end
        ifu_req_valid = 1'b0;
        chk("b2b_spacing_01", 32'(acc[1] - acc[0]), 32'h3);
        chk("b2b_spacing_12", 32'(acc[2] - acc[1]), 32'h3);
        drain("b2b_drain");

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060062_mem_arbiter.md
Name: ysyx_23060062_mem_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IFU) and load/store (LSU).
- Sequences each transaction as accept, then memory request handshake, then response wait, then return data to the owning requester.
- One transaction is outstanding at a time.
- Includes a response watchdog so a missing memory response cannot hang the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width = DATA_W/8.
- TIMEOUT, 255, cycles in RESP before an error response; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU fetch address (pc).
- ifu_resp_valid  out  1  one-cycle pulse, IFU response.
- ifu_rdata  out  DATA_W  fetched instruction.
- ifu_resp_err  out  1  qualifies ifu_resp_valid; timeout occurred.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_W  write data.
- lsu_wmask  in  DATA_W/8  byte enables.
- lsu_resp_valid  out  1  one-cycle pulse, LSU response (reads and writes).
- lsu_rdata  out  DATA_W  load data; 0 on write.
- lsu_resp_err  out  1  qualifies lsu_resp_valid.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  latched address.
- mem_wen  out  1  latched write enable (0 for IFU).
- mem_wdata  out  DATA_W  latched write data.
- mem_wmask  out  DATA_W/8  latched mask (0 for IFU).
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async on rst_n low):
  - state = IDLE, owner = IFU, last_grant = IFU, timer = 0.
  - All outputs 0, including latched mem_* fields and resp data.
- States: IDLE, REQ, RESP.
- IDLE:
  - Grant is combinational from the valids. `*_req_ready` = 1 only for the granted requester, and only in IDLE.
  - Fixed priority: LSU over IFU.
  - On accept, latch addr/wen/wdata/wmask and owner, then go to REQ.
  - With no valid request, stay in IDLE.
  - Requesters must hold valid and payload until ready.
- REQ:
  - mem_req_valid = 1 with latched fields, stable until mem_req_ready.
  - On mem_req_ready, go to RESP and clear timer.
- RESP:
  - Wait for mem_resp_valid.
  - When it arrives, register the result to the owner next cycle: resp_valid = 1, rdata = mem_rdata (LSU write: rdata = 0), err = 0. Go to IDLE.
  - Timer increments each cycle. If TIMEOUT != 0 and timer == TIMEOUT-1 with no response, emit resp_valid with err = 1 and rdata = 0, then go to IDLE.
- mem_resp_valid is ignored in IDLE and REQ; late responses after a timeout are dropped.
- Non-owner resp_valid is always 0. Response pulses last exactly one cycle.
- Minimum latency, with memory ready and responding the cycle after the handshake:
  - accept at N
  - mem handshake at N+1
  - mem_resp_valid at N+2
  - `*_resp_valid` at N+3
  - next accept possible at N+3 (IDLE).
- Simultaneous ifu/lsu valid in IDLE: only one is granted; the other sees ready = 0 and is retried next IDLE.
- rst_n asserted mid-transaction: immediate return to IDLE, no response pulse, transaction lost. Requesters re-issue after reset.

Optional Feature:
- Macro: YSYX_23060062_ARB_RR_EN.
- Defined: round-robin. When both valid, grant the requester that is not last_grant. last_grant updates on every accept. A single valid requester is always granted.
- Undefined: fixed LSU-over-IFU priority; last_grant is not implemented. IFU can starve under continuous LSU traffic.

Test Plan:
- Reset: drive rst_n low mid-RESP with mem never responding, release -> busy = 0, all *_resp_valid = 0, mem_req_valid = 0; next IFU request proceeds normally.
- IFU fetch: ifu_addr = 0x80000000, mem_req_ready = 1, mem_rdata = 0x00000413 one cycle after handshake -> mem_addr = 0x80000000, mem_wen = 0, mem_wmask = 0; ifu_resp_valid pulse at N+3 with ifu_rdata = 0x00000413, err = 0.
- LSU write: lsu_addr = 0x80001000, lsu_wdata = 0xDEADBEEF, lsu_wmask = 0x3, mem_req_ready delayed 3 cycles -> mem_* held stable for 3 cycles; lsu_resp_valid pulse with lsu_rdata = 0.
- Contention: ifu and lsu valid together for 4 transactions -> without macro grants LSU, LSU, LSU, LSU; with YSYX_23060062_ARB_RR_EN grants LSU, IFU, LSU, IFU.
- Timeout: TIMEOUT = 8, mem_resp_valid held 0 -> owner resp_valid with err = 1, rdata = 0 exactly 8 cycles after entering RESP; a late mem_resp_valid is ignored (no extra pulse).
- Back-to-back IFU fetches at 0x0, 0x4, 0x8 with zero-wait memory -> accepts every 3 cycles, rdata returned in order, never two responses in one cycle.
